// File: rtl/md_sched.sv
// md_sched: multi-cycle multiply/divide scheduler for the E stage.
// Owns HI/LO, the shadow result registers and the busy countdown.
// Raises the D-stage stall for HI/LO users while an operation is in flight.
// Optional feature macro: MD_SCHED_CANCEL_EN adds a 'cancel' input that
// aborts an in-flight operation and blocks a same-cycle issue (exception flush).
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_D,
`ifdef MD_SCHED_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_D
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   shadow_hi;
    logic [31:0]   shadow_lo;
    logic          shadow_wr;   // cleared for divide-by-zero so HI/LO survive
    logic          cancel_eff;

`ifdef MD_SCHED_CANCEL_EN
    assign cancel_eff = cancel;
`else
    assign cancel_eff = 1'b0;
`endif

    // Datapath results; all four are formed every cycle, op selects one.
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] div_u;
    logic [31:0] uq, ur;
    logic [31:0] mag_a, mag_b, mag_d;
    logic [31:0] mq, mr, sq, sr;
    logic [31:0] md_hi, md_lo;

    // Multiply/divide result formation (signed divide via magnitudes, which
    // also gives 0x80000000 / -1 = 0x80000000 without overflow trouble).
    always_comb begin
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};
        div_u  = (b == 32'd0) ? 32'd1 : b;
        uq     = a / div_u;
        ur     = a % div_u;
        mag_a  = a[31] ? (32'd0 - a) : a;
        mag_b  = b[31] ? (32'd0 - b) : b;
        mag_d  = (mag_b == 32'd0) ? 32'd1 : mag_b;
        mq     = mag_a / mag_d;
        mr     = mag_a % mag_d;
        sq     = (a[31] ^ b[31]) ? (32'd0 - mq) : mq;
        sr     = a[31] ? (32'd0 - mr) : mr;
        md_hi  = 32'd0;
        md_lo  = 32'd0;
        case (op[1:0])
            2'd0: begin md_hi = prod_s[63:32]; md_lo = prod_s[31:0]; end
            2'd1: begin md_hi = prod_u[63:32]; md_lo = prod_u[31:0]; end
            2'd2: begin md_hi = sr;            md_lo = sq;           end
            default: begin md_hi = ur;         md_lo = uq;           end
        endcase
    end

    // Scheduler FSM: issue into shadow regs, count down, commit on the last edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            shadow_hi <= '0;
            shadow_lo <= '0;
            shadow_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !cancel_eff) begin
                        case (op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                shadow_hi <= md_hi;
                                shadow_lo <= md_lo;
                                shadow_wr <= !(op[1] && (b == 32'd0));
                                cnt       <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                                state     <= BUSY;
                            end
                            3'd4:    hi <= a;
                            3'd5:    lo <= a;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    if (cancel_eff) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        shadow_hi <= '0;
                        shadow_lo <= '0;
                        shadow_wr <= 1'b0;
                    end else if (cnt == CW'(1)) begin
                        if (shadow_wr) begin
                            hi <= shadow_hi;
                            lo <= shadow_lo;
                        end
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Busy is a decode of the state register; stall covers the issue cycle too.
    assign busy    = (state == BUSY);
    assign stall_D = md_D & (busy | start);

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: scoreboard bench for md_sched. Each stimulus cycle pushes the
// expected busy/hi/lo/stall_D for that cycle from a timeline model (pending
// HI/LO writes tagged with the cycle they land, busy as "now < busy_until");
// a separate monitor pops and compares on the falling edge.
module tb_md_sched;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        start  = 1'b0;
    logic [2:0]  op     = 3'd0;
    logic [31:0] a      = 32'd0;
    logic [31:0] b      = 32'd0;
    logic        md_D   = 1'b0;
    logic        cancel = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_D;

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .md_D    (md_D),
`ifdef MD_SCHED_CANCEL_EN
        .cancel  (cancel),
`endif
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .stall_D (stall_D)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        stall;
    } exp_t;

    typedef struct {
        int          cyc;
        logic        wh;
        logic        wl;
        logic [31:0] h;
        logic [31:0] l;
    } upd_t;

    exp_t sb[$];
    upd_t upd[$];

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;
    int          busy_until = 0;

    task automatic push_upd(input int at, input logic wh, input logic wl,
                            input logic [31:0] h, input logic [31:0] l);
        upd_t u;
        u.cyc = at; u.wh = wh; u.wl = wl; u.h = h; u.l = l;
        upd.push_back(u);
    endtask

    // Reference behaviour of an accepted issue at the edge after cycle 'cyc'.
    task automatic model_issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, sq, sr, ps;
        logic [63:0]        pu;
        case (o)
            3'd0: begin
                sx = 64'(signed'(x)); sy = 64'(signed'(y));
                ps = sx * sy;
                busy_until = cyc + 1 + MC;
                push_upd(busy_until, 1'b1, 1'b1, ps[63:32], ps[31:0]);
            end
            3'd1: begin
                pu = 64'(x) * 64'(y);
                busy_until = cyc + 1 + MC;
                push_upd(busy_until, 1'b1, 1'b1, pu[63:32], pu[31:0]);
            end
            3'd2: begin
                busy_until = cyc + 1 + DC;
                if (y != 32'd0) begin
                    sx = 64'(signed'(x)); sy = 64'(signed'(y));
                    sq = sx / sy; sr = sx % sy;
                    push_upd(busy_until, 1'b1, 1'b1, sr[31:0], sq[31:0]);
                end
            end
            3'd3: begin
                busy_until = cyc + 1 + DC;
                if (y != 32'd0) push_upd(busy_until, 1'b1, 1'b1, x % y, x / y);
            end
            3'd4: push_upd(cyc + 1, 1'b1, 1'b0, x, 32'd0);
            3'd5: push_upd(cyc + 1, 1'b0, 1'b1, 32'd0, x);
            default: ;
        endcase
    endtask

    // One clock of stimulus: drive inputs, record this cycle's expectation,
    // then advance the model for the coming edge.
    task automatic tick(input logic rst_n, input logic st, input logic [2:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic md, input logic cn);
        exp_t e;
        upd_t u;
        logic mb;
        @(posedge clk);
        #1;
        reset = rst_n; start = st; op = o; a = x; b = y; md_D = md; cancel = cn;
        while (upd.size() > 0 && upd[0].cyc <= cyc) begin
            u = upd.pop_front();
            if (u.wh) m_hi = u.h;
            if (u.wl) m_lo = u.l;
        end
        if (!rst_n) begin
            upd.delete();
            busy_until = 0;
            m_hi = 32'd0;
            m_lo = 32'd0;
        end
        mb = (cyc < busy_until);
        e.cyc = cyc; e.busy = mb; e.hi = m_hi; e.lo = m_lo; e.stall = md & (mb | st);
        sb.push_back(e);
        if (rst_n && mb && cn) begin
            busy_until = cyc + 1;
            upd.delete();
        end else if (rst_n && !mb && st && !cn) begin
            if (o <= 3'd5) $display("issue cyc=%0d op=%0d a=%h b=%h", cyc, o, x, y);
            model_issue(o, x, y);
        end
    endtask

    task automatic idle();
        tick(1'b1, 1'b0, 3'd0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic md);
        tick(1'b1, 1'b1, o, x, y, md, 1'b0);
        while (cyc < busy_until) idle();
        idle();
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp, input int c);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", n, c, act, exp);
        end
    endtask

    // Monitor: compare the DUT against the expectation recorded for this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc != cyc) begin
                total++; bad++;
                $display("FAIL sched_slip cyc=%0d got=%0d want=%0d", cyc, cyc, e.cyc);
            end else begin
                chk("busy",    32'(busy),    32'(e.busy),  cyc);
                chk("hi",      hi,           e.hi,         cyc);
                chk("lo",      lo,           e.lo,         cyc);
                chk("stall_D", 32'(stall_D), 32'(e.stall), cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        st, md, cn;
        logic [2:0]  o;
        logic [31:0] x, y;

        tick(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 3'd4, 32'h55, 32'd0, 1'b1, 1'b0);
        idle();

        issue(3'd4, 32'h11, 32'd0, 1'b1);
        issue(3'd5, 32'h22, 32'd0, 1'b0);
        issue(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b1);
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        issue(3'd3, 32'd100, 32'd7, 1'b1);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(3'd4, 32'h11, 32'd0, 1'b0);
        issue(3'd5, 32'h22, 32'd0, 1'b0);
        issue(3'd2, 32'd5, 32'd0, 1'b1);
        issue(3'd3, 32'd9, 32'd0, 1'b0);
        issue(3'd4, 32'h1234, 32'd0, 1'b0);
        issue(3'd6, 32'hDEAD, 32'd3, 1'b1);
        issue(3'd7, 32'hBEEF, 32'd3, 1'b0);

        // mtlo and a second mult while busy must be ignored; start on the last busy cycle too
        tick(1'b1, 1'b1, 3'd0, 32'd3, 32'd4, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 3'd5, 32'hAAAA, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < MC - 2; i++) tick(1'b1, 1'b1, 3'd0, 32'd99, 32'd99, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 3'd5, 32'hBBBB, 32'd0, 1'b1, 1'b0);
        issue(3'd5, 32'hCCCC, 32'd0, 1'b1);

        // async reset between edges in cycle 3 of a divide
        tick(1'b1, 1'b1, 3'd3, 32'd1000, 32'd3, 1'b1, 1'b0);
        idle();
        idle();
        tick(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < DC + 2; i++) idle();

`ifdef MD_SCHED_CANCEL_EN
        issue(3'd4, 32'h77, 32'd0, 1'b0);
        tick(1'b1, 1'b1, 3'd0, 32'd6, 32'd7, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < MC + 1; i++) idle();
        tick(1'b1, 1'b1, 3'd4, 32'h99, 32'd0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 3'd0, 32'd2, 32'd3, 1'b0, 1'b1);
        idle();
`endif

        for (int i = 0; i < 500; i++) begin
            st = ($urandom_range(0, 3) == 0);
            o  = 3'($urandom_range(0, 7));
            x  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            case ($urandom_range(0, 7))
                0:       y = 32'd0;
                1:       y = 32'hFFFF_FFFF;
                2, 3:    y = 32'($urandom_range(1, 20));
                default: y = $urandom;
            endcase
            md = 1'($urandom_range(0, 1));
`ifdef MD_SCHED_CANCEL_EN
            cn = ($urandom_range(0, 15) == 0);
`else
            cn = 1'b0;
`endif
            tick(1'b1, st, o, x, y, md, cn);
        end
        for (int i = 0; i < DC + 2; i++) idle();

        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
